// File: rtl/food_pkg.sv
// Shared constants, FSM state type and one-hot helper for the food spawner.
package food_pkg;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam int MAX_COLS = 256;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        PROBE,
        SCAN
    } state_t;

    // Callers size-cast the result down to their own column count.
    function automatic logic [MAX_COLS-1:0] onehot(input logic [7:0] idx);
        onehot = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/food_spawner_if.sv
// Spawn-request / occupancy-probe / food-position bundle between the game side and the spawner.
interface food_spawner_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    localparam int ROW_W = $clog2(ROWS);

    logic             req;
    logic             probe_hit;
    logic [ROW_W-1:0] probe_row;
    logic [COLS-1:0]  probe_x;
    logic [ROW_W-1:0] y;
    logic [COLS-1:0]  x;
    logic             valid;
    logic             fail;
    logic             busy;

    modport master (
        output req, probe_hit,
        input  probe_row, probe_x, y, x, valid, fail, busy
    );

    modport slave (
        input  req, probe_hit,
        output probe_row, probe_x, y, x, valid, fail, busy
    );
endinterface

// File: rtl/food_lfsr.sv
// Free-running 16-bit Galois LFSR; exposes only the low OUT_W bits used as a candidate cell.
module food_lfsr
    import food_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
    parameter int                OUT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    output logic [OUT_W-1:0] cand
);
    logic [LFSR_W-1:0] state;

    // NOTE: clocked state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SEED;
        else       state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : '0);
    end

    assign cand = state[OUT_W-1:0];
endmodule

// File: rtl/food_spawner.sv
// Food-position generator: random draws with range/occupancy rejection.
// Optional sequential fallback scan when FOOD_SCAN_FALLBACK_EN is defined.
module food_spawner
    import food_pkg::*;
#(
    parameter int                ROWS      = 8,
    parameter int                COLS      = 8,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int                MAX_TRIES = 16,
    parameter int                INIT_ROW  = 3,
    parameter int                INIT_COL  = 6
) (
    input  logic         clk,
    input  logic         reset,
    food_spawner_if.slave bus
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    state_t           state, state_d;
    logic [ROW_W-1:0] cand_row, cand_row_d;
    logic [COL_W-1:0] cand_col, cand_col_d;
    logic [8:0]       tries, tries_d;
    logic [ROW_W-1:0] y_q, y_d;
    logic [COLS-1:0]  x_q, x_d;
    logic             valid_q, valid_d, fail_q, fail_d, busy_q, busy_d;
    logic             exhaust;
`ifdef FOOD_SCAN_FALLBACK_EN
    logic [ROW_W-1:0] scan_row, scan_row_d;
    logic [COL_W-1:0] scan_col, scan_col_d;
`endif

    logic [ROW_W+COL_W-1:0] lfsr_cand;
    logic [ROW_W-1:0]       lfsr_row;
    logic [COL_W-1:0]       lfsr_col;
    logic                   in_range;

    food_lfsr #(.SEED(SEED), .OUT_W(ROW_W + COL_W)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .cand  (lfsr_cand)
    );

    assign lfsr_row = lfsr_cand[ROW_W-1:0];
    assign lfsr_col = lfsr_cand[ROW_W+COL_W-1:ROW_W];
    assign in_range = (32'(lfsr_row) < ROWS) && (32'(lfsr_col) < COLS);

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_d    = state;
        cand_row_d = cand_row;
        cand_col_d = cand_col;
        tries_d    = tries;
        y_d        = y_q;
        x_d        = x_q;
        valid_d    = 1'b0;
        fail_d     = 1'b0;
        busy_d     = busy_q;
        exhaust    = 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
        scan_row_d = scan_row;
        scan_col_d = scan_col;
`endif
        case (state)
            IDLE: if (bus.req) begin
                state_d = GEN;
                tries_d = '0;
                busy_d  = 1'b1;
            end
            GEN: begin
                cand_row_d = lfsr_row;
                cand_col_d = lfsr_col;
                tries_d    = tries + 9'd1;
                if (in_range)                        state_d = PROBE;
                else if (tries_d >= 9'(MAX_TRIES))   exhaust = 1'b1;
            end
            PROBE: begin
                if (!bus.probe_hit) begin
                    y_d     = cand_row;
                    x_d     = COLS'(onehot(8'(cand_col)));
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (tries >= 9'(MAX_TRIES)) begin
                    exhaust = 1'b1;
                end else begin
                    state_d = GEN;
                end
            end
`ifdef FOOD_SCAN_FALLBACK_EN
            SCAN: begin
                if (!bus.probe_hit) begin
                    y_d     = scan_row;
                    x_d     = COLS'(onehot(8'(scan_col)));
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (32'(scan_row) == ROWS - 1 && 32'(scan_col) == COLS - 1) begin
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (32'(scan_col) == COLS - 1) begin
                    scan_col_d = '0;
                    scan_row_d = scan_row + 1'b1;
                end else begin
                    scan_col_d = scan_col + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (exhaust) begin
`ifdef FOOD_SCAN_FALLBACK_EN
            state_d    = SCAN;
            scan_row_d = '0;
            scan_col_d = '0;
`else
            state_d = IDLE;
            fail_d  = 1'b1;
            busy_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cand_row <= '0;
            cand_col <= '0;
            tries    <= '0;
            y_q      <= ROW_W'(INIT_ROW);
            x_q      <= COLS'(onehot(8'(INIT_COL)));
            valid_q  <= 1'b0;
            fail_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
            scan_row <= '0;
            scan_col <= '0;
`endif
        end else begin
            state    <= state_d;
            cand_row <= cand_row_d;
            cand_col <= cand_col_d;
            tries    <= tries_d;
            y_q      <= y_d;
            x_q      <= x_d;
            valid_q  <= valid_d;
            fail_q   <= fail_d;
            busy_q   <= busy_d;
`ifdef FOOD_SCAN_FALLBACK_EN
            scan_row <= scan_row_d;
            scan_col <= scan_col_d;
`endif
        end
    end

    // The probe is combinational so the body store can answer within the same cycle.
    always_comb begin
        bus.probe_row = '0;
        bus.probe_x   = '0;
        if (state == PROBE) begin
            bus.probe_row = cand_row;
            bus.probe_x   = COLS'(onehot(8'(cand_col)));
        end
`ifdef FOOD_SCAN_FALLBACK_EN
        else if (state == SCAN) begin
            bus.probe_row = scan_row;
            bus.probe_x   = COLS'(onehot(8'(scan_col)));
        end
`endif
    end

    assign bus.y     = y_q;
    assign bus.x     = x_q;
    assign bus.valid = valid_q;
    assign bus.fail  = fail_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner: 8x8 (MAX_TRIES=4), 6x5 grid, and scan fallback when
// FOOD_SCAN_FALLBACK_EN is defined.
module tb_food_spawner;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef FOOD_SCAN_FALLBACK_EN
    localparam int OCC_LAT = 8 + 64;
`else
    localparam int OCC_LAT = 8;
`endif

    food_spawner_if #(.ROWS(8), .COLS(8)) bus_a ();
    food_spawner_if #(.ROWS(6), .COLS(5)) bus_b ();

    logic hit_a;
    assign bus_a.probe_hit = hit_a;
    assign bus_b.probe_hit = 1'b0;

    food_spawner #(.ROWS(8), .COLS(8), .SEED(16'hACE1), .MAX_TRIES(4),
                   .INIT_ROW(3), .INIT_COL(6)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );

    food_spawner #(.ROWS(6), .COLS(5), .SEED(16'hACE1), .MAX_TRIES(16),
                   .INIT_ROW(3), .INIT_COL(2)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

`ifdef FOOD_SCAN_FALLBACK_EN
    food_spawner_if #(.ROWS(8), .COLS(8)) bus_c ();
    logic scan_all;
    assign bus_c.probe_hit = scan_all ? 1'b1 : !(bus_c.probe_row == 3'd7 && bus_c.probe_x[7]);

    food_spawner #(.ROWS(8), .COLS(8), .SEED(16'hACE1), .MAX_TRIES(2),
                   .INIT_ROW(3), .INIT_COL(6)) dut_c (
        .clk(clk), .reset(reset), .bus(bus_c)
    );
`endif

    // Reference LFSR: same seed and reset as the DUTs, so it tracks their draw stream.
    logic [15:0] model;
    always @(posedge clk or posedge reset) begin
        if (reset) model <= 16'hACE1;
        else       model <= {1'b0, model[15:1]} ^ (model[0] ? 16'hB400 : 16'h0000);
    end

    logic b_probe_bad = 1'b0;
    always @(negedge clk) begin
        if (bus_b.probe_x != '0 &&
            (32'(bus_b.probe_row) >= 6 || $countones(bus_b.probe_x) != 1))
            b_probe_bad <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int which, input logic v);
        case (which)
            0: bus_a.req = v;
            1: bus_b.req = v;
`ifdef FOOD_SCAN_FALLBACK_EN
            2: bus_c.req = v;
`endif
            default: ;
        endcase
    endtask

    // {busy, fail, valid} of the selected instance
    function automatic logic [2:0] status(input int which);
        case (which)
            0: status = {bus_a.busy, bus_a.fail, bus_a.valid};
            1: status = {bus_b.busy, bus_b.fail, bus_b.valid};
`ifdef FOOD_SCAN_FALLBACK_EN
            2: status = {bus_c.busy, bus_c.fail, bus_c.valid};
`endif
            default: status = 3'b000;
        endcase
    endfunction

    logic [2:0] seen_row;
    logic [7:0] seen_x;

    // Pulse req for one edge (E) and wait for valid/fail; lat counts edges after E.
    task automatic do_req(input int which, input int budget, output int lat,
                          output logic got_valid, output logic got_fail,
                          output logic busy_e, output logic [15:0] cand);
        logic [2:0] s;
        @(negedge clk);
        set_req(which, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_req(which, 1'b0);
        cand      = model;
        busy_e    = status(which)[2];
        lat       = -1;
        got_valid = 1'b0;
        got_fail  = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (n == 1) begin
                seen_row = bus_a.probe_row;
                seen_x   = bus_a.probe_x;
            end
            s = status(which);
            if (s[0] || s[1]) begin
                lat       = n;
                got_valid = s[0];
                got_fail  = s[1];
                break;
            end
        end
    endtask

    int          lat;
    logic        gv, gf, be;
    logic [15:0] cand;
    logic [2:0]  exp_y;
    logic [7:0]  exp_x;
    int          vcount;

    initial begin
        bus_a.req = 1'b0;
        bus_b.req = 1'b0;
        hit_a     = 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
        bus_c.req = 1'b0;
        scan_all  = 1'b0;
`endif
        reset = 1'b1;
        #1;
        check("rst_y", 32'(bus_a.y), 32'd3);
        check("rst_x", 32'(bus_a.x), 32'h40);
        check("rst_flags", {29'd0, status(0)}, 32'd0);
        check("rst_probe_x", 32'(bus_a.probe_x), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // All cells free: placement two edges after the request edge.
        for (int i = 0; i < 3; i++) begin
            do_req(0, 10, lat, gv, gf, be, cand);
            exp_y = cand[2:0];
            exp_x = 8'(1) << cand[5:3];
            check("free_busy", 32'(be), 32'd1);
            check("free_lat", lat, 32'd2);
            check("free_valid", 32'(gv), 32'd1);
            check("free_probe_row", 32'(seen_row), 32'(exp_y));
            check("free_probe_x", 32'(seen_x), 32'(exp_x));
            check("free_y", 32'(bus_a.y), 32'(exp_y));
            check("free_x", 32'(bus_a.x), 32'(exp_x));
            check("free_x_onehot", $countones(bus_a.x), 32'd1);
            @(negedge clk);
            check("free_pulse_end", {29'd0, status(0)}, 32'd0);
        end

        // Asynchronous reset in the middle of PROBE.
        @(negedge clk);
        bus_a.req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_a.req = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_y", 32'(bus_a.y), 32'd3);
        check("midrst_x", 32'(bus_a.x), 32'h40);
        check("midrst_flags", {29'd0, status(0)}, 32'd0);
        check("midrst_probe_x", 32'(bus_a.probe_x), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_req(0, 10, lat, gv, gf, be, cand);
        check("postrst_lat", lat, 32'd2);
        check("postrst_y", 32'(bus_a.y), 32'(cand[2:0]));
        check("postrst_x", 32'(bus_a.x), 32'(8'(1) << cand[5:3]));

        // req held across E, E+1 and the valid edge: only one placement.
        @(negedge clk);
        bus_a.req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cand = model;
        @(negedge clk);
        @(negedge clk);
        bus_a.req = 1'b0;
        check("busy_valid", 32'(bus_a.valid), 32'd1);
        check("busy_y", 32'(bus_a.y), 32'(cand[2:0]));
        vcount = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            vcount += int'(bus_a.valid) + int'(bus_a.busy);
        end
        check("busy_no_extra", vcount, 32'd0);

        // All cells occupied.
        hit_a = 1'b1;
        exp_y = bus_a.y;
        exp_x = bus_a.x;
        do_req(0, 100, lat, gv, gf, be, cand);
        check("occ_lat", lat, OCC_LAT);
        check("occ_fail", 32'(gf), 32'd1);
        check("occ_no_valid", 32'(gv), 32'd0);
        check("occ_y", 32'(bus_a.y), 32'(exp_y));
        check("occ_x", 32'(bus_a.x), 32'(exp_x));
        @(negedge clk);
        check("occ_after", {29'd0, status(0)}, 32'd0);
        hit_a = 1'b0;

        // Non-power-of-two grid.
        for (int r = 0; r < 200; r++) begin
            do_req(1, 64, lat, gv, gf, be, cand);
            check("b_resp", 32'(lat > 0), 32'd1);
            if (gv) begin
                check("b_y_range", 32'(32'(bus_b.y) < 6), 32'd1);
                check("b_x_onehot", $countones(bus_b.x), 32'd1);
            end
        end
        check("b_probe_range", 32'(b_probe_bad), 32'd0);

`ifdef FOOD_SCAN_FALLBACK_EN
        scan_all = 1'b0;
        do_req(2, 100, lat, gv, gf, be, cand);
        check("scan_valid", 32'(gv), 32'd1);
        check("scan_y", 32'(bus_c.y), 32'd7);
        check("scan_x", 32'(bus_c.x), 32'h80);
        scan_all = 1'b1;
        do_req(2, 100, lat, gv, gf, be, cand);
        check("scan_full_fail", 32'(gf), 32'd1);
        check("scan_full_lat", lat, 32'd68);
        check("scan_full_y", 32'(bus_c.y), 32'd7);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
